// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clkdiv_pkg;

  // Default width of the divisor and the period counter.
  localparam int CNT_W_DEF = 8;

  // Smallest divisor that produces a real divided clock.
  localparam int DIV_MIN = 2;

  // Number of whole clkin cycles that pos_hi is high in one period.
  function automatic logic [31:0] half_of(input logic [31:0] n);
    return n >> 1;
  endfunction

  // Odd divisors need the extra half cycle from the negedge stage.
  function automatic logic is_odd(input logic [31:0] n);
    return n[0];
  endfunction

endpackage

// File: rtl/clkdiv_neg_stage.sv
// Negedge half-cycle extension and odd/even output select.
// This is the only logic clocked on the falling edge of clkin.
module clkdiv_neg_stage (
  input  logic clkin,
  input  logic i_pos_hi,
  input  logic i_odd,
  output logic o_clkout
);

  logic r_neg_q;

  // Delay pos_hi by half a cycle; held at 0 for even divisors.
  always_ff @(negedge clkin) begin
    r_neg_q <= i_odd & i_pos_hi;
  end

  // Odd divisors stretch the high phase by the delayed copy.
  always_comb begin
    o_clkout = i_pos_hi;
    if (i_odd) begin
      o_clkout = i_pos_hi | r_neg_q;
    end
  end

endmodule

// File: rtl/clock_divider_prog.sv
// Runtime-programmable 50%-duty integer clock divider.
// A new divisor is held pending and only takes effect at a period
// boundary, so the running period always completes untouched.
// Stopping and starting also happen only at period boundaries.
module clock_divider_prog
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             i_enable,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_div_value,
  input  logic             i_err_clr,
  output logic             o_clkout,
  output logic [CNT_W-1:0] o_div_active,
  output logic             o_busy,
  output logic             o_err
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DEF_CNT = CNT_W'(DEFAULT_DIV - 1);
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(DIV_MIN);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_active;
  logic [CNT_W-1:0] r_pending;
  logic             r_busy;
  logic             r_err;
  logic             r_pos_hi;

  logic             w_at_end;
  logic             w_boundary;
  logic             w_apply;
  logic [CNT_W-1:0] w_n_next;
  logic [CNT_W-1:0] w_h_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_pos_hi_next;
  logic             w_load_ok;
  logic             w_load_bad;
  logic             w_odd;

  // Period boundary detection, divisor switch-over and next counter value.
  always_comb begin
    w_at_end      = (r_cnt == (r_div_active - ONE));
    w_boundary    = w_at_end & i_enable;
    w_apply       = w_boundary & r_busy;
    w_n_next      = w_apply ? r_pending : r_div_active;
    w_h_next      = CNT_W'(half_of(32'(w_n_next)));
    w_cnt_next    = r_cnt + ONE;
    if (w_boundary) begin
      w_cnt_next = '0;
    end else if (w_at_end) begin
      // Stopped: park at the end of the period.
      w_cnt_next = r_cnt;
    end
    w_pos_hi_next = (w_cnt_next < w_h_next);
    if (w_at_end && !i_enable) begin
      w_pos_hi_next = 1'b0;
    end
    w_load_ok     = i_load & (i_div_value >= MIN_DIV);
    w_load_bad    = i_load & (i_div_value <  MIN_DIV);
  end

  // Period counter, active divisor and the posedge half of the output.
  always_ff @(posedge clkin) begin
    if (reset) begin
      r_cnt        <= DEF_CNT;
      r_div_active <= DEF_DIV;
      r_pos_hi     <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_next;
      r_div_active <= w_n_next;
      r_pos_hi     <= w_pos_hi_next;
    end
  end

  // Pending divisor, busy flag and sticky error flag.
  always_ff @(posedge clkin) begin
    if (reset) begin
      r_pending <= DEF_DIV;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      // A load on the applying edge re-arms busy for the next boundary.
      if (w_load_ok) begin
        r_pending <= i_div_value;
        r_busy    <= 1'b1;
      end else if (w_apply) begin
        r_busy    <= 1'b0;
      end
      // Setting wins over clearing on the same edge.
      if (w_load_bad) begin
        r_err <= 1'b1;
      end else if (i_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign w_odd = is_odd(32'(r_div_active));

  clkdiv_neg_stage u_neg_stage (
    .clkin    (clkin),
    .i_pos_hi (r_pos_hi),
    .i_odd    (w_odd),
    .o_clkout (o_clkout)
  );

  assign o_div_active = r_div_active;
  assign o_busy       = r_busy;
  assign o_err        = r_err;

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
Runtime-programmable integer clock divider producing a 50%-duty-cycle clkout for both odd and even divisors. It is the parametrised successor of the fixed divide-by-3 block. Additions over a fixed divider:
- loadable divisor, applied glitch-free at period boundaries
- enable with clean stop and start
- status outputs
Sits at the clock-generation layer and feeds downstream lab/peripheral logic.

Parameters:
CNT_W, 8, width of divisor and internal counter; legal divisors are 2..2^CNT_W-1.
DEFAULT_DIV, 3, divisor active after reset; must satisfy 2 <= DEFAULT_DIV < 2^CNT_W.

Ports:
clkin  input  1  source clock.
reset  input  1  synchronous, active-high, sampled on posedge clkin.
enable  input  1  run request; stop and start occur only at period boundaries.
load  input  1  single-cycle strobe; captures div_value.
div_value  input  CNT_W  requested divisor N.
err_clr  input  1  clears err.
clkout  output  1  divided clock.
div_active  output  CNT_W  divisor currently in effect.
busy  output  1  a loaded divisor is pending and not yet applied.
err  output  1  sticky; an illegal divisor (<2) was loaded.

Behaviour:
- Reset values:
  - cnt = N-1, where N = DEFAULT_DIV (parked at the end of a period)
  - pos_hi = 0, neg_q = 0, clkout = 0
  - div_active = DEFAULT_DIV, pending = DEFAULT_DIV
  - busy = 0, err = 0
- Posedge counter cnt runs 0..N-1. It wraps to 0 at the "boundary edge", the posedge where cnt == N-1 and enable = 1.
- Let H = floor(N/2).
  - pos_hi is registered on posedge: pos_hi <= (cnt_next < H) while running; 0 when stopped.
  - neg_q is registered on negedge: neg_q <= pos_hi, and is cleared when pos_hi = 0.
- Even N: clkout = pos_hi. High for H clkin periods, low for H.
- Odd N: clkout = pos_hi | neg_q. High for H + 0.5 periods, low for H + 0.5.
  - Only the odd path uses neg_q; for even N, neg_q is forced 0.
- Start latency: with enable = 1 at reset release, clkout rises at the first posedge after reset deasserts, which is the boundary edge.
- Load:
  - On a load posedge with div_value >= 2: pending <= div_value and busy <= 1.
  - A second load while busy overwrites pending; the last one wins.
- Load with div_value < 2: ignored; err <= 1. busy and pending are unchanged.
- err clearing: err_clr clears err. If load-illegal and err_clr occur on the same edge, err stays 1.
- Apply:
  - At a boundary edge with busy = 1: div_active <= pending, N takes the new value from that edge (cnt <= 0, new H used), and busy <= 0.
  - No runt or stretched pulse at a divisor change: the old period always completes.
- Load on the same edge as the boundary: not applied this boundary; busy = 1 and it applies at the next boundary.
- Enable deasserted:
  - The current period completes.
  - At cnt == N-1 the counter holds; pos_hi and neg_q go 0, so clkout stays low.
  - A pending divisor is applied when the block next restarts.
- Enable reasserted while parked: the next posedge is a boundary edge and clkout rises.
- Enable toggling mid-period has no effect until the boundary.
- Reset mid-operation:
  - At the reset posedge: pos_hi = 0, cnt = N-1 with N = DEFAULT_DIV.
  - neg_q clears at the following negedge, so clkout is low within 0.5 clkin periods.
  - The pending divisor is discarded.
- Arithmetic:
  - All compares are unsigned CNT_W bits.
  - cnt_next = (cnt == N-1) ? 0 : cnt + 1. No modulo operator.
  - H is computed from div_active as a right shift.
- Max divisor 2^CNT_W - 1: cnt never overflows.

Decomposition:
- Package clkdiv_pkg holds:
  - CNT_W default
  - DIV_MIN = 2
  - half_of(N) function
  - is_odd(N) function
- One sub-module, clkdiv_neg_stage: the negedge neg_q register plus the odd/even output mux. It isolates the only negedge logic for clock-tree and STA review.

Test Plan:
- Reset, DEFAULT_DIV = 3, enable = 1 -> clkout period 3 clkin, high 1.5 periods, first rise on the 1st posedge after reset release.
- load div_value = 4 mid-period -> busy = 1 until the next boundary; then period 4, high exactly 2 periods; old period length preserved.
- load div_value = 255 (CNT_W = 8), then load 7 before the boundary -> only 7 applied; period 7, high 3.5; div_active = 7.
- load div_value = 1, then err_clr -> err = 1 the cycle after load with div_active unchanged; err = 0 after err_clr.
- Drop enable at cnt = 1 with N = 5 -> period finishes, clkout low and holding; reassert -> rise on the next posedge, period 5.
- Assert reset while clkout is high with N = 6 -> clkout low within 0.5 clkin, div_active = 3 after reset, busy = 0.
